hazard_ctrl: RTL

- Hazard and sequencing controller for the 5-stage rvpipeline.
- Drives the stall, flush and forward controls of the F/D, D/E, E/M and M/W pipeline registers.
- Detects load-use and branch hazards, and selects operand forwarding for the Execute stage.
- Runs a wait-state FSM that freezes the whole pipeline while data memory is not ready, with a timeout error.

---
 rtl/hazard_defs.sv | 14 +
 rtl/forward_sel.sv | 25 ++
 rtl/hazard_ctrl.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/hazard_defs.sv
// rtl/hazard_defs.sv - shared forward-select codes and wait-FSM state encodings for hazard_ctrl
package hazard_defs;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_WAIT    = 2'd1,
    ST_TIMEOUT = 2'd2
  } hz_state_t;

endpackage

// File: rtl/forward_sel.sv
// rtl/forward_sel.sv - Execute operand forward select for one source register
// Memory-stage producer has priority over Writeback; x0 is never forwarded.
module forward_sel
  import hazard_defs::*;
#(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] i_rs_e,
  input  logic [REG_AW-1:0] i_rd_m,
  input  logic [REG_AW-1:0] i_rd_w,
  input  logic              i_reg_write_m,
  input  logic              i_reg_write_w,
  output logic [1:0]        o_fwd
);

  always_comb begin
    o_fwd = FWD_RF;
    if (i_reg_write_m && (i_rd_m != '0) && (i_rd_m == i_rs_e)) begin
      o_fwd = FWD_MEM;
    end else if (i_reg_write_w && (i_rd_w != '0) && (i_rd_w == i_rs_e)) begin
      o_fwd = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - stall/flush/forward control and memory wait-state FSM for the 5-stage pipeline
// Optional HAZ_PERF_EN adds saturating StallCnt/FlushCnt performance counters.
module hazard_ctrl
  import hazard_defs::*;
#(
  parameter int REG_AW   = 5,
  parameter int WAIT_MAX = 16,
  parameter int CNT_W    = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] Rs1D,
  input  logic [REG_AW-1:0] Rs2D,
  input  logic [REG_AW-1:0] Rs1E,
  input  logic [REG_AW-1:0] Rs2E,
  input  logic [REG_AW-1:0] RdE,
  input  logic              ResultSrcE0,
  input  logic              PCSrcE,
  input  logic [REG_AW-1:0] RdM,
  input  logic [REG_AW-1:0] RdW,
  input  logic              RegWriteM,
  input  logic              RegWriteW,
  input  logic              MemReqM,
  input  logic              MemReadyM,
  output logic [1:0]        ForwardAE,
  output logic [1:0]        ForwardBE,
  output logic              StallF,
  output logic              StallD,
  output logic              StallE,
  output logic              StallM,
  output logic              StallW,
  output logic              FlushD,
  output logic              FlushE,
`ifdef HAZ_PERF_EN
  output logic [31:0]       StallCnt,
  output logic [31:0]       FlushCnt,
`endif
  output logic              MemErr
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_MAX - 1);

  hz_state_t        r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_mem_err;

  logic [1:0] w_fwd_a;
  logic [1:0] w_fwd_b;
  logic       w_lw_stall;
  logic       w_mem_stall;

  forward_sel #(.REG_AW(REG_AW)) u_fwd_a (
    .i_rs_e        (Rs1E),
    .i_rd_m        (RdM),
    .i_rd_w        (RdW),
    .i_reg_write_m (RegWriteM),
    .i_reg_write_w (RegWriteW),
    .o_fwd         (w_fwd_a)
  );

  forward_sel #(.REG_AW(REG_AW)) u_fwd_b (
    .i_rs_e        (Rs2E),
    .i_rd_m        (RdM),
    .i_rd_w        (RdW),
    .i_reg_write_m (RegWriteM),
    .i_reg_write_w (RegWriteW),
    .o_fwd         (w_fwd_b)
  );

  assign w_lw_stall  = ResultSrcE0 && (RdE != '0) && ((RdE == Rs1D) || (RdE == Rs2D));
  // TIMEOUT drops the freeze for one cycle so the stuck access can retire.
  assign w_mem_stall = MemReqM && !MemReadyM && (r_state != ST_TIMEOUT);

  always_comb begin
    ForwardAE = FWD_RF;
    ForwardBE = FWD_RF;
    StallF    = 1'b0;
    StallD    = 1'b0;
    StallE    = 1'b0;
    StallM    = 1'b0;
    StallW    = 1'b0;
    FlushD    = 1'b1;
    FlushE    = 1'b1;
    if (reset) begin
      ForwardAE = w_fwd_a;
      ForwardBE = w_fwd_b;
      if (w_mem_stall) begin
        StallF = 1'b1;
        StallD = 1'b1;
        StallE = 1'b1;
        StallM = 1'b1;
        StallW = 1'b1;
        FlushD = 1'b0;
        FlushE = 1'b0;
      end else begin
        StallF = w_lw_stall;
        StallD = w_lw_stall;
        FlushD = PCSrcE;
        FlushE = w_lw_stall || PCSrcE;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= ST_RUN;
      r_cnt     <= '0;
      r_mem_err <= 1'b0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (w_mem_stall) begin
            r_state <= ST_WAIT;
            r_cnt   <= CNT_W'(1);
          end
        end
        ST_WAIT: begin
          if (MemReadyM || !MemReqM) begin
            r_state <= ST_RUN;
            r_cnt   <= '0;
          end else if (r_cnt == CNT_LAST) begin
            r_state   <= ST_TIMEOUT;
            r_mem_err <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: begin
          r_state <= ST_RUN;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign MemErr = r_mem_err;

`ifdef HAZ_PERF_EN
  logic [31:0] r_stall_cnt;
  logic [31:0] r_flush_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (StallD && (r_stall_cnt != 32'hFFFF_FFFF)) r_stall_cnt <= r_stall_cnt + 32'd1;
      if (FlushE && (r_flush_cnt != 32'hFFFF_FFFF)) r_flush_cnt <= r_flush_cnt + 32'd1;
    end
  end

  assign StallCnt = r_stall_cnt;
  assign FlushCnt = r_flush_cnt;
`endif

endmodule
